// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_gen
// Description : VGA raster counters, sync/blank decode delay-aligned to the
//               draw-chain RGB, and 3-3-2 to 4-4-4 colour expansion to pins.
// Revision    : 1.0  initial release
// ============================================================================
module vga_scan_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_DLY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        pix_en,
    input  logic [7:0]  RGB_in,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        VGA_HS_N,
    output logic        VGA_VS_N,
    output logic        VGA_BLANK_N,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B
);

    localparam int          c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] c_H_LAST   = 11'(c_H_TOTAL - 1);
    localparam logic [10:0] c_V_LAST   = 11'(c_V_TOTAL - 1);
    localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] c_VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    // bit positions inside a delay-line entry
    localparam int c_B_ACT = 2;
    localparam int c_B_HS  = 1;
    localparam int c_B_VS  = 0;

    logic [10:0] r_hcnt;
    logic [10:0] r_vcnt;
    logic        r_sof;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [2:0]  w_timing;
    logic [2:0]  r_dly [PIPE_DLY];
    logic [2:0]  w_dly_out;
    logic        r_hs_n;
    logic        r_vs_n;
    logic        r_blank_n;
    logic [3:0]  r_red;
    logic [3:0]  r_green;
    logic [3:0]  r_blue;

    assign w_h_wrap = (r_hcnt == c_H_LAST);
    assign w_v_wrap = (r_vcnt == c_V_LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hcnt <= 11'd0;
            r_vcnt <= 11'd0;
        end else if (pix_en) begin
            if (w_h_wrap) begin
                r_hcnt <= 11'd0;
                r_vcnt <= w_v_wrap ? 11'd0 : r_vcnt + 11'd1;
            end else begin
                r_hcnt <= r_hcnt + 11'd1;
            end
        end
    end

    // Pulses alongside the tick that reloads (0,0), so reset release never fires it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sof <= 1'b0;
        end else begin
            r_sof <= pix_en && w_h_wrap && w_v_wrap;
        end
    end

    always_comb begin
        w_timing         = 3'b000;
        w_timing[c_B_ACT] = (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
        w_timing[c_B_HS]  = (r_hcnt >= c_HS_FIRST) && (r_hcnt <= c_HS_LAST);
        w_timing[c_B_VS]  = (r_vcnt >= c_VS_FIRST) && (r_vcnt <= c_VS_LAST);
    end

    // Reset fill of zero means "blank, syncs inactive", so no stale sync leaks out.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                r_dly[i] <= 3'b000;
            end
        end else if (pix_en) begin
            r_dly[0] <= w_timing;
            for (int i = 1; i < PIPE_DLY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign w_dly_out = r_dly[PIPE_DLY-1];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hs_n    <= 1'b1;
            r_vs_n    <= 1'b1;
            r_blank_n <= 1'b0;
            r_red     <= 4'h0;
            r_green   <= 4'h0;
            r_blue    <= 4'h0;
        end else if (pix_en) begin
            r_hs_n    <= ~w_dly_out[c_B_HS];
            r_vs_n    <= ~w_dly_out[c_B_VS];
            r_blank_n <= w_dly_out[c_B_ACT];
            if (w_dly_out[c_B_ACT]) begin
                r_red   <= {RGB_in[7:5], RGB_in[7]};
                r_green <= {RGB_in[4:2], RGB_in[4]};
                r_blue  <= {RGB_in[1:0], RGB_in[1:0]};
            end else begin
                r_red   <= 4'h0;
                r_green <= 4'h0;
                r_blue  <= 4'h0;
            end
        end
    end

    assign pixelX       = r_hcnt;
    assign pixelY       = r_vcnt;
    assign startOfFrame = r_sof;
    assign VGA_HS_N     = r_hs_n;
    assign VGA_VS_N     = r_vs_n;
    assign VGA_BLANK_N  = r_blank_n;
    assign VGA_R        = r_red;
    assign VGA_G        = r_green;
    assign VGA_B        = r_blue;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_gen
// Description : Directed bench: full-size instance for line timing and colour,
//               reduced-size PIPE_DLY=3 instance for frame-level timing.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_scan_gen;

    logic        clk = 1'b0;
    logic        resetN;
    logic        pix_en;
    logic [7:0]  RGB_in;

    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, VGA_HS_N, VGA_VS_N, VGA_BLANK_N;
    logic [3:0]  VGA_R, VGA_G, VGA_B;

    logic [10:0] s_pixelX, s_pixelY;
    logic        s_sof, s_hs_n, s_vs_n, s_blank_n;
    logic [3:0]  s_r, s_g, s_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_scan_gen dut (
        .clk(clk), .resetN(resetN), .pix_en(pix_en), .RGB_in(RGB_in),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .VGA_HS_N(VGA_HS_N), .VGA_VS_N(VGA_VS_N), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    // 15 x 8 raster: 120 ticks per frame, 3-stage alignment pipe
    vga_scan_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DLY(3)
    ) dut_s (
        .clk(clk), .resetN(resetN), .pix_en(pix_en), .RGB_in(RGB_in),
        .pixelX(s_pixelX), .pixelY(s_pixelY), .startOfFrame(s_sof),
        .VGA_HS_N(s_hs_n), .VGA_VS_N(s_vs_n), .VGA_BLANK_N(s_blank_n),
        .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n, mx, my, vlow, hlow, bhi, sofs, cl, unst;
        logic [10:0] px, spx;
        logic pb, en, ph;

        resetN = 1'b0;
        pix_en = 1'b1;
        RGB_in = 8'b101_010_01;
        tick(2);
        chk("rst_x",     pixelX, 0);
        chk("rst_y",     pixelY, 0);
        chk("rst_sof",   startOfFrame, 0);
        chk("rst_hs",    VGA_HS_N, 1);
        chk("rst_vs",    VGA_VS_N, 1);
        chk("rst_blank", VGA_BLANK_N, 0);
        chk("rst_rgb",   {VGA_R, VGA_G, VGA_B}, 12'h000);

        resetN = 1'b1;
        tick(1);
        chk("x1",       pixelX, 1);
        chk("x1_blank", VGA_BLANK_N, 0);
        chk("x1_hs",    VGA_HS_N, 1);
        tick(1);
        chk("x2_blank", VGA_BLANK_N, 1);
        chk("x2_rgb",   {VGA_R, VGA_G, VGA_B}, 12'hB45);

        pix_en = 1'b0;
        tick(3);
        chk("hold_x",   pixelX, 2);
        chk("hold_rgb", {VGA_R, VGA_G, VGA_B}, 12'hB45);
        chk("hold_sof", startOfFrame, 0);
        pix_en = 1'b1;

        tick(639);
        chk("x641_blank", VGA_BLANK_N, 1);
        tick(1);
        chk("x642_blank", VGA_BLANK_N, 0);
        chk("x642_rgb",   {VGA_R, VGA_G, VGA_B}, 12'h000);
        tick(15);
        chk("hs_before", VGA_HS_N, 1);
        tick(1);
        chk("hs_first", VGA_HS_N, 0);
        tick(95);
        chk("hs_last", VGA_HS_N, 0);
        tick(1);
        chk("hs_after", VGA_HS_N, 1);
        chk("vs_line0", VGA_VS_N, 1);
        tick(45);
        chk("x799", pixelX, 799);
        chk("y0",   pixelY, 0);
        tick(1);
        chk("wrap_x",   pixelX, 0);
        chk("wrap_y",   pixelY, 1);
        chk("wrap_sof", startOfFrame, 0);
        tick(1);
        chk("l1x1_blank", VGA_BLANK_N, 0);
        RGB_in = 8'b000_111_10;
        tick(1);
        chk("l1x2_blank", VGA_BLANK_N, 1);
        chk("l1x2_rgb",   {VGA_R, VGA_G, VGA_B}, 12'h0FA);

        // asynchronous reset mid-line, checked before any clock edge
        tick(298);
        chk("pre_rst_x", pixelX, 300);
        resetN = 1'b0;
        #2;
        chk("arst_x",     pixelX, 0);
        chk("arst_y",     pixelY, 0);
        chk("arst_blank", VGA_BLANK_N, 0);
        chk("arst_rgb",   {VGA_R, VGA_G, VGA_B}, 12'h000);
        chk("arst_sx",    s_pixelX, 0);
        tick(1);
        resetN = 1'b1;

        tick(3);
        chk("rel_x",       pixelX, 3);
        chk("rel_y",       pixelY, 0);
        chk("rel_sof",     s_sof, 0);
        chk("s_k3_blank",  s_blank_n, 0);
        tick(1);
        chk("s_k4_blank",  s_blank_n, 1);
        chk("s_k4_rgb",    {s_r, s_g, s_b}, 12'h0FA);

        n = 4; mx = 0; my = 0;
        while (s_sof !== 1'b1 && n < 1000) begin
            if (int'(s_pixelX) > mx) mx = int'(s_pixelX);
            if (int'(s_pixelY) > my) my = int'(s_pixelY);
            tick(1);
            n++;
        end
        chk("s_first_sof", n, 120);
        chk("s_max_x", mx, 14);
        chk("s_max_y", my, 7);
        chk("s_sof_x", s_pixelX, 0);
        chk("s_sof_y", s_pixelY, 0);
        tick(1);
        chk("s_sof_width", s_sof, 0);

        vlow = 0; hlow = 0; bhi = 0; sofs = 0;
        for (int i = 0; i < 120; i++) begin
            if (i != 0) tick(1);
            if (s_vs_n === 1'b0)    vlow++;
            if (s_hs_n === 1'b0)    hlow++;
            if (s_blank_n === 1'b1) bhi++;
            if (s_sof === 1'b1)     sofs++;
        end
        chk("s_vs_low",   vlow, 30);
        chk("s_hs_low",   hlow, 24);
        chk("s_blank_hi", bhi, 32);
        chk("s_sof_cnt",  sofs, 1);
        chk("s_period",   s_sof, 1);

        // half-rate enable: sync to a pulse, then measure one period
        ph = 1'b0; unst = 0;
        for (int pass = 0; pass < 2; pass++) begin
            cl = 0;
            do begin
                pix_en = ph; en = ph; ph = ~ph;
                px = pixelX; spx = s_pixelX; pb = s_blank_n;
                tick(1);
                cl++;
                if (!en && (pixelX !== px || s_pixelX !== spx || s_blank_n !== pb)) unst++;
            end while (s_sof !== 1'b1 && cl < 2000);
        end
        chk("half_period", cl, 240);
        chk("half_stable", unst, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
